// File: rtl/debug_step_controller_if.sv
// debug_step_controller_if: command and phase-decoder handshake bundle for debug_step_controller.
//   Host side:    CMD_VALID, CMD, CMD_COUNT -> controller; CMD_READY <- controller
//   Decoder side: STOPPED, DEBUG_ACTIVE, DEBUG_STEP_ACK, PC -> controller;
//                 DEBUG_STOPX, DEBUG_STEP_REQ <- controller
//   Status:       HALTED, STEPS_DONE, DONE, ERROR <- controller
//   With DEBUG_BREAKPOINT_EN defined: BP_ADDR, BP_ENABLE -> controller; BP_HIT <- controller
// master = controller view, slave = host/decoder/environment view.
interface debug_step_controller_if #(
    parameter int unsigned COUNT_W = 16
);
    logic               CMD_VALID;
    logic [1:0]         CMD;
    logic [COUNT_W-1:0] CMD_COUNT;
    logic               CMD_READY;
    logic               STOPPED;
    logic               DEBUG_ACTIVE;
    logic               DEBUG_STEP_ACK;
    logic [15:0]        PC;
    logic               DEBUG_STOPX;
    logic               DEBUG_STEP_REQ;
    logic               HALTED;
    logic [COUNT_W-1:0] STEPS_DONE;
    logic               DONE;
    logic               ERROR;
`ifdef DEBUG_BREAKPOINT_EN
    logic [15:0]        BP_ADDR;
    logic               BP_ENABLE;
    logic               BP_HIT;
`endif

    modport master (
        input  CMD_VALID, CMD, CMD_COUNT, STOPPED, DEBUG_ACTIVE, DEBUG_STEP_ACK, PC,
`ifdef DEBUG_BREAKPOINT_EN
        input  BP_ADDR, BP_ENABLE,
        output BP_HIT,
`endif
        output CMD_READY, DEBUG_STOPX, DEBUG_STEP_REQ, HALTED, STEPS_DONE, DONE, ERROR
    );

    modport slave (
        output CMD_VALID, CMD, CMD_COUNT, STOPPED, DEBUG_ACTIVE, DEBUG_STEP_ACK, PC,
`ifdef DEBUG_BREAKPOINT_EN
        output BP_ADDR, BP_ENABLE,
        input  BP_HIT,
`endif
        input  CMD_READY, DEBUG_STOPX, DEBUG_STEP_REQ, HALTED, STEPS_DONE, DONE, ERROR
    );
endinterface

// File: rtl/debug_step_controller.sv
// debug_step_controller: debug-side master for the CPU phase sequencer stop/step interface.
// Accepts NOP/STOP/RUN/STEP commands from the debug host, drives DEBUG_STOPX and the
// four-phase DEBUG_STEP_REQ/ACK handshake, counts completed steps and pulses DONE.
// Ports:
//   CLK    clock
//   RESET  asynchronous reset, active high
//   bus    debug_step_controller_if.master (command, decoder handshake, status)
// Parameters: COUNT_W (step counter width), ACK_TIMEOUT (0 = no timeout),
//   RESET_HALTED (1: come out of reset requesting a stop).
// Optional feature: define DEBUG_BREAKPOINT_EN to add PC breakpoint (BP_ADDR/BP_ENABLE/BP_HIT).
// All outputs are registered; they are computed from the next state.
module debug_step_controller #(
    parameter int unsigned COUNT_W      = 16,
    parameter int unsigned ACK_TIMEOUT  = 255,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    debug_step_controller_if.master bus
);
    localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam bit             TMO_EN   = (ACK_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_STOP = 2'b01;
    localparam logic [1:0] CMD_RUN  = 2'b10;
    localparam logic [1:0] CMD_STEP = 2'b11;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_HALTING = 3'd1,
        ST_HALT    = 3'd2,
        ST_REQ_HI  = 3'd3,
        ST_REQ_LO  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] steps_q, steps_d;
    logic               pending_q, pending_d;
    logic               stopx_q, stopx_d;
    logic               req_q, req_d;
    logic               halted_q, halted_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               cmd_fire;
    logic               tmo_hit;
    logic               bp_match;
    logic               parked;
    logic [COUNT_W-1:0] steps_inc;
    logic [COUNT_W-1:0] cmd_count_norm;

`ifdef DEBUG_BREAKPOINT_EN
    logic               bp_hit_q, bp_hit_d;

    assign bp_match   = bus.BP_ENABLE && (bus.PC == bus.BP_ADDR);
    assign bus.BP_HIT = bp_hit_q;
`else
    logic               unused_pc;

    assign bp_match  = 1'b0;
    assign unused_pc = ^bus.PC;
`endif

    assign cmd_fire       = bus.CMD_VALID && ready_q;
    assign tmo_hit        = TMO_EN && (tmo_q == TMO_LAST);
    assign parked         = bus.STOPPED && bus.DEBUG_ACTIVE && !bus.DEBUG_STEP_ACK;
    // Step counter saturates at all-ones rather than wrapping.
    assign steps_inc      = (&steps_q) ? steps_q : steps_q + COUNT_W'(1);
    // A zero count still performs one step.
    assign cmd_count_norm = (bus.CMD_COUNT == '0) ? COUNT_W'(1) : bus.CMD_COUNT;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        tmo_d     = '0;
        count_d   = count_q;
        steps_d   = steps_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        error_d   = error_q;
`ifdef DEBUG_BREAKPOINT_EN
        bp_hit_d  = bp_hit_q;
`endif

        // Any accepted command clears the sticky status flags.
        if (cmd_fire) begin
            error_d  = 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
            bp_hit_d = 1'b0;
`endif
        end

        case (state_q)
            ST_RUN: begin
                if (cmd_fire && (bus.CMD == CMD_STOP)) begin
                    state_d   = ST_HALTING;
                    pending_d = 1'b0;
                end else if (cmd_fire && (bus.CMD == CMD_STEP)) begin
                    state_d   = ST_HALTING;
                    pending_d = 1'b1;
                    count_d   = cmd_count_norm;
                    steps_d   = '0;
                end else if (bp_match) begin
                    state_d   = ST_HALTING;
                    pending_d = 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
                    bp_hit_d  = 1'b1;
`endif
                end
            end

            ST_HALTING: begin
                if (parked) begin
                    pending_d = 1'b0;
                    if (pending_q) begin
                        state_d = ST_REQ_HI;
                    end else begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d   = ST_HALT;
                    pending_d = 1'b0;
                    error_d   = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_HALT: begin
                if (cmd_fire) begin
                    case (bus.CMD)
                        CMD_STEP: begin
                            state_d = ST_REQ_HI;
                            count_d = cmd_count_norm;
                            steps_d = '0;
                        end
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STOP: done_d  = 1'b1;
                        CMD_NOP:  ;
                        default:  ;
                    endcase
                end
            end

            ST_REQ_HI: begin
                if (bus.DEBUG_STEP_ACK) begin
                    state_d = ST_REQ_LO;
                end else if (tmo_hit) begin
                    state_d = ST_HALT;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_REQ_LO: begin
                if (!bus.DEBUG_STEP_ACK) begin
                    steps_d = steps_inc;
                    if ((steps_inc == count_q) || bp_match) begin
                        state_d = ST_HALT;
                        done_d  = 1'b1;
`ifdef DEBUG_BREAKPOINT_EN
                        if (bp_match) begin
                            bp_hit_d = 1'b1;
                        end
`endif
                    end else begin
                        state_d = ST_REQ_HI;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_HALT;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: state_d = ST_RUN;
        endcase

        // Registered outputs follow the state being entered.
        stopx_d  = (state_d != ST_RUN);
        req_d    = (state_d == ST_REQ_HI);
        halted_d = (state_d == ST_HALT);
        ready_d  = (state_d == ST_RUN) || (state_d == ST_HALT);
    end

    // State and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= RESET_HALTED ? ST_HALTING : ST_RUN;
            tmo_q     <= '0;
            count_q   <= '0;
            steps_q   <= '0;
            pending_q <= 1'b0;
            stopx_q   <= RESET_HALTED;
            req_q     <= 1'b0;
            halted_q  <= 1'b0;
            ready_q   <= !RESET_HALTED;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef DEBUG_BREAKPOINT_EN
            bp_hit_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            count_q   <= count_d;
            steps_q   <= steps_d;
            pending_q <= pending_d;
            stopx_q   <= stopx_d;
            req_q     <= req_d;
            halted_q  <= halted_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef DEBUG_BREAKPOINT_EN
            bp_hit_q  <= bp_hit_d;
`endif
        end
    end

    assign bus.CMD_READY      = ready_q;
    assign bus.DEBUG_STOPX    = stopx_q;
    assign bus.DEBUG_STEP_REQ = req_q;
    assign bus.HALTED         = halted_q;
    assign bus.STEPS_DONE     = steps_q;
    assign bus.DONE           = done_q;
    assign bus.ERROR          = error_q;
endmodule

// File: tb/tb_debug_step_controller.sv
// tb_debug_step_controller: table-driven, hand-written and randomized checks of
// debug_step_controller against a behavioural phase-decoder model (ACK_TIMEOUT=8).
module tb_debug_step_controller;
    localparam int unsigned COUNT_W = 16;
    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_STOP = 2'b01;
    localparam logic [1:0] C_RUN  = 2'b10;
    localparam logic [1:0] C_STEP = 2'b11;

    logic CLK;
    logic RESET;

    debug_step_controller_if #(.COUNT_W(COUNT_W)) bus ();

    debug_step_controller #(
        .COUNT_W      (COUNT_W),
        .ACK_TIMEOUT  (8),
        .RESET_HALTED (1'b0)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests;
    int n_fail;

    // Phase decoder model knobs and protocol monitors.
    int          ack_lat;
    int          ack_never;
    int          req_age;
    int          pc_run;
    int          mon_pulses, mon_dones, mon_hi, mon_hi_max, mon_viol;
    logic        prev_req, prev_stopx;
    logic [15:0] stopx_rise_pc;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] cnt;
        int          lat;
        int          never;
        int          exp_pulses;
        int          exp_steps;
        int          exp_err;
        int          exp_done;
        int          exp_hi;     // -1: REQ-high length not checked
    } vec_t;

    vec_t vecs[6];

    function automatic void check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    task automatic mon_clear();
        mon_pulses = 0;
        mon_dones  = 0;
        mon_hi     = 0;
        mon_hi_max = 0;
        mon_viol   = 0;
    endtask

    // One clock: sample just after the edge, then update the decoder model inputs.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (bus.DONE) mon_dones++;
        if (bus.DEBUG_STEP_REQ) begin
            if (!prev_req) begin
                mon_pulses++;
                if (bus.DEBUG_STEP_ACK) mon_viol++;
            end
            mon_hi++;
            if (mon_hi > mon_hi_max) mon_hi_max = mon_hi;
        end else begin
            mon_hi = 0;
        end
        if ((bus.DEBUG_STEP_REQ || bus.DEBUG_STEP_ACK) && !bus.DEBUG_STOPX) mon_viol++;
        if (bus.DEBUG_STOPX && !prev_stopx) stopx_rise_pc = bus.PC;
        prev_req   = bus.DEBUG_STEP_REQ;
        prev_stopx = bus.DEBUG_STOPX;

        bus.STOPPED      = bus.DEBUG_STOPX;
        bus.DEBUG_ACTIVE = bus.DEBUG_STOPX;
        if (bus.DEBUG_STEP_REQ) begin
            req_age++;
            bus.DEBUG_STEP_ACK = (ack_never == 0) && (req_age >= ack_lat);
        end else begin
            req_age = 0;
            bus.DEBUG_STEP_ACK = 1'b0;
        end
        if (pc_run != 0) bus.PC = bus.PC + 16'd1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
    endtask

    // Issue one command and run until DONE (STOP/STEP) or for a short settle (RUN/NOP).
    // While the controller is busy, random commands are offered and must be ignored.
    task automatic run_op(input logic [1:0] cmd, input logic [15:0] cnt, input int lat,
                          input int never, input string tag);
        int i;
        ack_lat   = lat;
        ack_never = never;
        mon_clear();
        check({tag, " ready"}, int'(bus.CMD_READY), 1);
        bus.CMD       = cmd;
        bus.CMD_COUNT = cnt;
        bus.CMD_VALID = 1'b1;
        tick();
        bus.CMD_VALID = 1'b0;
        if (cmd == C_STOP || cmd == C_STEP) begin
            i = 0;
            while (mon_dones == 0 && i < 400) begin
                if (!bus.CMD_READY && $urandom_range(0, 3) == 0) begin
                    bus.CMD_VALID = 1'b1;
                    bus.CMD       = 2'($urandom_range(0, 3));
                    bus.CMD_COUNT = 16'($urandom_range(0, 7));
                end else begin
                    bus.CMD_VALID = 1'b0;
                end
                tick();
                i++;
            end
            bus.CMD_VALID = 1'b0;
        end
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   m_halted, m_err, m_steps, eff, exp_p, exp_d;
        logic [1:0]  c;
        logic [15:0] n;
        int   lat, nev;

        n_tests = 0;
        n_fail  = 0;
        ack_lat = 4; ack_never = 0; req_age = 0; pc_run = 0;
        prev_req = 1'b0; prev_stopx = 1'b0; stopx_rise_pc = '0;
        mon_clear();
        RESET = 1'b1;
        bus.CMD_VALID = 1'b0; bus.CMD = C_NOP; bus.CMD_COUNT = '0;
        bus.STOPPED = 1'b0; bus.DEBUG_ACTIVE = 1'b0; bus.DEBUG_STEP_ACK = 1'b0;
        bus.PC = '0;
`ifdef DEBUG_BREAKPOINT_EN
        bus.BP_ADDR = '0; bus.BP_ENABLE = 1'b0;
`endif

        vecs[0] = '{C_STEP, 16'd3, 4, 0, 3, 3, 0, 1, -1};
        vecs[1] = '{C_STEP, 16'd0, 4, 0, 1, 1, 0, 1, -1};
        vecs[2] = '{C_STEP, 16'd5, 1, 0, 5, 5, 0, 1, -1};
        vecs[3] = '{C_STEP, 16'd2, 4, 1, 1, 0, 1, 1, 8};
        vecs[4] = '{C_STOP, 16'd0, 4, 0, 0, 0, 0, 1, -1};
        vecs[5] = '{C_STEP, 16'd2, 7, 0, 2, 2, 0, 1, 7};

        // Reset values.
        do_reset();
        check("reset stopx",  int'(bus.DEBUG_STOPX), 0);
        check("reset req",    int'(bus.DEBUG_STEP_REQ), 0);
        check("reset ready",  int'(bus.CMD_READY), 1);
        check("reset halted", int'(bus.HALTED), 0);
        check("reset steps",  int'(bus.STEPS_DONE), 0);
        check("reset done",   int'(bus.DONE), 0);
        check("reset error",  int'(bus.ERROR), 0);

        // RUN -> STOP -> HALT.
        run_op(C_STOP, 16'd0, 4, 0, "stop");
        check("stop stopx",  int'(bus.DEBUG_STOPX), 1);
        check("stop halted", int'(bus.HALTED), 1);
        check("stop dones",  mon_dones, 1);

        // Table of step/stop scenarios from HALT.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].cmd, vecs[i].cnt, vecs[i].lat, vecs[i].never, $sformatf("vec%0d", i));
            check($sformatf("vec%0d pulses", i), mon_pulses, vecs[i].exp_pulses);
            check($sformatf("vec%0d steps", i),  int'(bus.STEPS_DONE), vecs[i].exp_steps);
            check($sformatf("vec%0d error", i),  int'(bus.ERROR), vecs[i].exp_err);
            check($sformatf("vec%0d dones", i),  mon_dones, vecs[i].exp_done);
            check($sformatf("vec%0d halted", i), int'(bus.HALTED), 1);
            check($sformatf("vec%0d protocol", i), mon_viol, 0);
            if (vecs[i].exp_hi >= 0)
                check($sformatf("vec%0d req_hi_len", i), mon_hi_max, vecs[i].exp_hi);
        end

        // Reset while REQ is high: REQ drops and controller is in RUN immediately.
        ack_never = 1;
        bus.CMD = C_STEP; bus.CMD_COUNT = 16'd2; bus.CMD_VALID = 1'b1;
        tick();
        bus.CMD_VALID = 1'b0;
        tick(); tick();
        check("midrst req before", int'(bus.DEBUG_STEP_REQ), 1);
        #2 RESET = 1'b1;
        #1;
        check("midrst req",    int'(bus.DEBUG_STEP_REQ), 0);
        check("midrst stopx",  int'(bus.DEBUG_STOPX), 0);
        check("midrst ready",  int'(bus.CMD_READY), 1);
        check("midrst halted", int'(bus.HALTED), 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        ack_never = 0;
        tick();

        // Randomized commands against an abstract model: running/halted, error, step count.
        m_halted = 0; m_err = 0; m_steps = 0;
        for (int k = 0; k < 40; k++) begin
            c   = 2'($urandom_range(0, 3));
            n   = 16'($urandom_range(0, 4));
            lat = $urandom_range(1, 6);
            nev = ($urandom_range(0, 7) == 0) ? 1 : 0;
            eff = (n == 16'd0) ? 1 : int'(n);
            exp_p = 0;
            exp_d = 0;
            m_err = 0;
            case (c)
                C_STOP: begin
                    m_halted = 1;
                    exp_d    = 1;
                end
                C_STEP: begin
                    m_halted = 1;
                    exp_d    = 1;
                    if (nev != 0) begin
                        exp_p   = 1;
                        m_steps = 0;
                        m_err   = 1;
                    end else begin
                        exp_p   = eff;
                        m_steps = eff;
                    end
                end
                C_RUN:   m_halted = 0;
                default: ;
            endcase
            run_op(c, n, lat, nev, $sformatf("rnd%0d", k));
            check($sformatf("rnd%0d cmd%0d halted", k, c), int'(bus.HALTED), m_halted);
            check($sformatf("rnd%0d cmd%0d stopx", k, c),  int'(bus.DEBUG_STOPX), m_halted);
            check($sformatf("rnd%0d cmd%0d steps", k, c),  int'(bus.STEPS_DONE), m_steps);
            check($sformatf("rnd%0d cmd%0d error", k, c),  int'(bus.ERROR), m_err);
            check($sformatf("rnd%0d cmd%0d dones", k, c),  mon_dones, exp_d);
            check($sformatf("rnd%0d cmd%0d pulses", k, c), mon_pulses, exp_p);
            check($sformatf("rnd%0d cmd%0d protocol", k, c), mon_viol, 0);
        end

`ifdef DEBUG_BREAKPOINT_EN
        // Breakpoint while running with PC counting up.
        do_reset();
        bus.PC = 16'h0030; bus.BP_ADDR = 16'h0040; bus.BP_ENABLE = 1'b1;
        pc_run = 1;
        stopx_rise_pc = '0;
        mon_clear();
        for (int i = 0; i < 100 && !bus.HALTED; i++) tick();
        pc_run = 0;
        bus.BP_ENABLE = 1'b0;
        check("bp stop pc", int'(stopx_rise_pc), 16'h0040);
        check("bp hit",     int'(bus.BP_HIT), 1);
        check("bp halted",  int'(bus.HALTED), 1);
        check("bp dones",   mon_dones, 1);
        run_op(C_STOP, 16'd0, 4, 0, "bp clear");
        check("bp hit cleared", int'(bus.BP_HIT), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
